// File: rtl/corner_sb_pkg.sv
// -----------------------------------------------------------------------------
// corner_sb_pkg
// Shared definitions for the corner switch-block configuration tile:
//   - route-mux select encodings (SEL_ZERO / SEL_STRAIGHT / SEL_ROT / SEL_PAD)
//   - configuration FSM state type
//   - cfg_bits(): configuration payload size for a given channel width
//     (two select bits per output track, two output channels).
// -----------------------------------------------------------------------------
package corner_sb_pkg;

  localparam logic [1:0] SEL_ZERO     = 2'd0;
  localparam logic [1:0] SEL_STRAIGHT = 2'd1;
  localparam logic [1:0] SEL_ROT      = 2'd2;
  localparam logic [1:0] SEL_PAD      = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } cfg_state_t;

  function automatic int cfg_bits(input int width);
    return 4 * width;
  endfunction

endpackage

// File: rtl/sb_route_mux4.sv
// -----------------------------------------------------------------------------
// sb_route_mux4
// One output track of the corner switch block: 4:1 mux selected by a 2-bit
// route select, with a test override that forces the straight-turn source.
// Ports:
//   i_sel       route select (SEL_* encoding)
//   i_test_en   force SEL_STRAIGHT regardless of i_sel
//   i_straight  straight-turn source bit
//   i_rot       rotated-index source bit
//   i_pad       I/O pad source bit
//   o_q         routed output bit
// -----------------------------------------------------------------------------
module sb_route_mux4
  import corner_sb_pkg::*;
(
  input  logic [1:0] i_sel,
  input  logic       i_test_en,
  input  logic       i_straight,
  input  logic       i_rot,
  input  logic       i_pad,
  output logic       o_q
);

  logic [1:0] w_sel;

  assign w_sel = i_test_en ? SEL_STRAIGHT : i_sel;

  always_comb begin
    case (w_sel)
      SEL_ZERO:     o_q = 1'b0;
      SEL_STRAIGHT: o_q = i_straight;
      SEL_ROT:      o_q = i_rot;
      default:      o_q = i_pad;
    endcase
  end

endmodule

// File: rtl/corner_sb_cfg_tile.sv
// -----------------------------------------------------------------------------
// corner_sb_cfg_tile
// Bottom-left corner switch-block tile with a framed configuration chain.
// Route selects are shifted serially into a shadow register and committed
// atomically to the active register by a frame-checking FSM. The routing
// datapath is purely combinational from the active register and inputs.
//
// Build option: define CFG_PARITY_EN to extend the frame by one trailing
// even-parity bit; a commit with bad parity is rejected.
//
// Ports:
//   prog_clk, prog_reset     clock, synchronous active-high reset
//   ccff_head / ccff_tail    config chain serial in / out (shadow MSB)
//   cfg_shift_en             shift one config bit this cycle
//   cfg_commit               copy shadow to active (checked)
//   test_enable              force straight-through routing
//   chanx_right_in/out       X channel, CHAN_WIDTH tracks
//   chany_top_in/out         Y channel, CHAN_WIDTH tracks
//   right_pad_in, top_pad_in NUM_PADS pad inputs per side
//   cfg_done / cfg_error     sticky result of the last commit
// -----------------------------------------------------------------------------
module corner_sb_cfg_tile
  import corner_sb_pkg::*;
#(
  parameter int CHAN_WIDTH = 30,
  parameter int NUM_PADS   = 4
)(
  input  logic                  prog_clk,
  input  logic                  prog_reset,
  input  logic                  ccff_head,
  input  logic                  cfg_shift_en,
  input  logic                  cfg_commit,
  input  logic                  test_enable,
  input  logic [CHAN_WIDTH-1:0] chanx_right_in,
  input  logic [CHAN_WIDTH-1:0] chany_top_in,
  input  logic [NUM_PADS-1:0]   right_pad_in,
  input  logic [NUM_PADS-1:0]   top_pad_in,
  output logic                  ccff_tail,
  output logic [CHAN_WIDTH-1:0] chanx_right_out,
  output logic [CHAN_WIDTH-1:0] chany_top_out,
  output logic                  cfg_done,
  output logic                  cfg_error
);

  localparam int CFG_BITS = cfg_bits(CHAN_WIDTH);
`ifdef CFG_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_BITS = CFG_BITS + PAR_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

  logic [FRAME_BITS-1:0] r_shadow;
  logic [CFG_BITS-1:0]   r_active;
  logic [CNT_W-1:0]      r_count;
  logic                  r_ovf;
  logic                  r_done;
  logic                  r_error;
  cfg_state_t            r_state;
  cfg_state_t            w_state_nxt;

  logic w_parity_ok;
  logic w_do_shift;
  logic w_frame_start;
  logic w_commit_ok;
  logic w_commit_err;

  // Even parity over the whole frame, parity bit included.
`ifdef CFG_PARITY_EN
  assign w_parity_ok = ~^r_shadow;
`else
  assign w_parity_ok = 1'b1;
`endif

  // FSM: state register
  always_ff @(posedge prog_clk) begin
    if (prog_reset) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  // FSM: next-state logic. Commit wins over a simultaneous shift.
  always_comb begin
    w_state_nxt = r_state;
    if (cfg_commit) begin
      w_state_nxt = IDLE;
    end else if (cfg_shift_en) begin
      case (r_state)
        IDLE:    w_state_nxt = (FRAME_BITS == 1) ? FULL : SHIFT;
        SHIFT:   if (r_count == CNT_FULL - CNT_W'(1)) w_state_nxt = FULL;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // FSM: output/strobe logic
  always_comb begin
    w_do_shift    = cfg_shift_en & ~cfg_commit;
    w_frame_start = w_do_shift & (r_state == IDLE);
    w_commit_ok   = cfg_commit & (r_state == FULL) & ~r_ovf & w_parity_ok;
    w_commit_err  = cfg_commit & ~w_commit_ok;
  end

  // Shadow/active registers, frame counter, overflow and sticky status
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_shadow <= '0;
      r_active <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      if (w_do_shift) r_shadow <= {r_shadow[FRAME_BITS-2:0], ccff_head};
      // Parity bit (if any) sits in the LSB; the payload is the upper bits.
      if (w_commit_ok) r_active <= r_shadow[FRAME_BITS-1 -: CFG_BITS];

      if (cfg_commit) begin
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else if (w_do_shift) begin
        if (r_state == IDLE)          r_count <= CNT_W'(1);
        else if (r_count != CNT_FULL) r_count <= r_count + CNT_W'(1);
        // Shifting past a full frame poisons the next commit.
        if (r_state == FULL)          r_ovf   <= 1'b1;
      end

      if (w_frame_start) begin
        r_done  <= 1'b0;
        r_error <= 1'b0;
      end
      if (w_commit_ok)  r_done  <= 1'b1;
      if (w_commit_err) r_error <= 1'b1;
    end
  end

  assign ccff_tail = r_shadow[FRAME_BITS-1];
  assign cfg_done  = r_done;
  assign cfg_error = r_error;

  // Route muxes: X outputs draw from the Y channel / top pads and vice versa.
  genvar gi;
  generate
    for (gi = 0; gi < CHAN_WIDTH; gi++) begin : g_track
      sb_route_mux4 u_mux_x (
        .i_sel      (r_active[2*gi +: 2]),
        .i_test_en  (test_enable),
        .i_straight (chany_top_in[gi]),
        .i_rot      (chany_top_in[(gi+1) % CHAN_WIDTH]),
        .i_pad      (top_pad_in[gi % NUM_PADS]),
        .o_q        (chanx_right_out[gi])
      );
      sb_route_mux4 u_mux_y (
        .i_sel      (r_active[2*CHAN_WIDTH + 2*gi +: 2]),
        .i_test_en  (test_enable),
        .i_straight (chanx_right_in[gi]),
        .i_rot      (chanx_right_in[(gi+1) % CHAN_WIDTH]),
        .i_pad      (right_pad_in[gi % NUM_PADS]),
        .o_q        (chany_top_out[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_corner_sb_cfg_tile.sv
// -----------------------------------------------------------------------------
// tb_corner_sb_cfg_tile
// Self-checking bench for corner_sb_cfg_tile: directed scenarios followed by
// randomized frames, compared against a behavioural model built on a queue of
// shifted bits and a frame-length count.
// -----------------------------------------------------------------------------
module tb_corner_sb_cfg_tile;
  import corner_sb_pkg::*;

  localparam int CW       = 30;
  localparam int NP       = 4;
  localparam int CFG_BITS = cfg_bits(CW);
`ifdef CFG_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_BITS = CFG_BITS + PAR;

  logic          prog_clk = 1'b0;
  logic          prog_reset, ccff_head, cfg_shift_en, cfg_commit, test_enable;
  logic [CW-1:0] chanx_right_in, chany_top_in;
  logic [NP-1:0] right_pad_in, top_pad_in;
  logic          ccff_tail, cfg_done, cfg_error;
  logic [CW-1:0] chanx_right_out, chany_top_out;

  corner_sb_cfg_tile #(.CHAN_WIDTH(CW), .NUM_PADS(NP)) dut (
    .prog_clk        (prog_clk),
    .prog_reset      (prog_reset),
    .ccff_head       (ccff_head),
    .cfg_shift_en    (cfg_shift_en),
    .cfg_commit      (cfg_commit),
    .test_enable     (test_enable),
    .chanx_right_in  (chanx_right_in),
    .chany_top_in    (chany_top_in),
    .right_pad_in    (right_pad_in),
    .top_pad_in      (top_pad_in),
    .ccff_tail       (ccff_tail),
    .chanx_right_out (chanx_right_out),
    .chany_top_out   (chany_top_out),
    .cfg_done        (cfg_done),
    .cfg_error       (cfg_error)
  );

  always #5 prog_clk = ~prog_clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit                  m_hist[$];   // most recent shifted bits, oldest first
  int                  m_n;         // shifts in the current frame (0 = idle)
  logic [CFG_BITS-1:0] m_active;
  bit                  m_done, m_error;
  bit                  rand_data;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Shadow bit j (0 = most recently shifted bit).
  function automatic bit m_shadow_bit(input int j);
    int idx;
    idx = m_hist.size() - 1 - j;
    if (idx < 0) return 1'b0;
    return m_hist[idx];
  endfunction

  function automatic bit m_par_ok();
    bit p;
    p = 1'b0;
    if (PAR == 0) return 1'b1;
    for (int j = 0; j < FRAME_BITS; j++) p ^= m_shadow_bit(j);
    return (p == 1'b0);
  endfunction

  task automatic m_clock(input bit sh, input bit b, input bit cm);
    if (cm) begin
      if (m_n == FRAME_BITS && m_par_ok()) begin
        for (int k = 0; k < CFG_BITS; k++) m_active[k] = m_shadow_bit(k + PAR);
        m_done = 1'b1;
      end else begin
        m_error = 1'b1;
      end
      m_n = 0;
    end else if (sh) begin
      if (m_n == 0) begin
        m_done  = 1'b0;
        m_error = 1'b0;
      end
      m_hist.push_back(b);
      if (m_hist.size() > FRAME_BITS) void'(m_hist.pop_front());
      m_n++;
    end
  endtask

  task automatic check_all(input string tag);
    logic [CW-1:0] ex, ey;
    int sx, sy;
    for (int i = 0; i < CW; i++) begin
      sx = test_enable ? 1 : int'(m_active[2*i +: 2]);
      sy = test_enable ? 1 : int'(m_active[2*CW + 2*i +: 2]);
      case (sx)
        0:       ex[i] = 1'b0;
        1:       ex[i] = chany_top_in[i];
        2:       ex[i] = chany_top_in[(i+1) % CW];
        default: ex[i] = top_pad_in[i % NP];
      endcase
      case (sy)
        0:       ey[i] = 1'b0;
        1:       ey[i] = chanx_right_in[i];
        2:       ey[i] = chanx_right_in[(i+1) % CW];
        default: ey[i] = right_pad_in[i % NP];
      endcase
    end
    chk({tag, "_xout"}, chanx_right_out, ex);
    chk({tag, "_yout"}, chany_top_out, ey);
    chk({tag, "_tail"}, ccff_tail, m_shadow_bit(FRAME_BITS - 1));
    chk({tag, "_done"}, cfg_done, m_done);
    chk({tag, "_error"}, cfg_error, m_error);
  endtask

  task automatic step(input bit sh, input bit b, input bit cm);
    ccff_head    = b;
    cfg_shift_en = sh;
    cfg_commit   = cm;
    if (rand_data) begin
      chanx_right_in = CW'($urandom);
      chany_top_in   = CW'($urandom);
      right_pad_in   = NP'($urandom);
      top_pad_in     = NP'($urandom);
      test_enable    = ($urandom_range(0, 15) == 0);
    end
    @(posedge prog_clk);
    m_clock(sh, b, cm);
    #1;
    cfg_shift_en = 1'b0;
    cfg_commit   = 1'b0;
    check_all("step");
  endtask

  task automatic do_reset();
    prog_reset   = 1'b1;
    cfg_shift_en = 1'($urandom);
    cfg_commit   = 1'($urandom);
    ccff_head    = 1'($urandom);
    @(posedge prog_clk);
    @(posedge prog_clk);
    m_hist.delete();
    m_n      = 0;
    m_active = '0;
    m_done   = 1'b0;
    m_error  = 1'b0;
    #1;
    prog_reset   = 1'b0;
    cfg_shift_en = 1'b0;
    cfg_commit   = 1'b0;
    check_all("rst");
  endtask

  function automatic logic [FRAME_BITS-1:0] mk_frame(input logic [CFG_BITS-1:0] cfg);
    logic [FRAME_BITS-1:0] f;
`ifdef CFG_PARITY_EN
    f = {cfg, ^cfg};
`else
    f = cfg;
`endif
    return f;
  endfunction

  function automatic logic [CFG_BITS-1:0] rnd_cfg();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[CFG_BITS-1:0];
  endfunction

  // First bit shifted is the frame MSB; extra shifts beyond the frame are random.
  task automatic shift_frame(input logic [FRAME_BITS-1:0] f, input int nshift);
    bit b;
    for (int k = 0; k < nshift; k++) begin
      b = (k < FRAME_BITS) ? f[FRAME_BITS-1-k] : 1'($urandom);
      step(1'b1, b, 1'b0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CFG_BITS-1:0]   c;
    logic [FRAME_BITS-1:0] f;
    bit                    sent[$];
    int                    d;

    prog_reset = 1'b1; ccff_head = 1'b0; cfg_shift_en = 1'b0; cfg_commit = 1'b0;
    test_enable = 1'b0; rand_data = 1'b0;
    chanx_right_in = '0; chany_top_in = '0; right_pad_in = '0; top_pad_in = '0;

    // Reset state with all-ones channel inputs
    do_reset();
    chanx_right_in = '1; chany_top_in = '1;
    #1;
    chk("rst_xout", chanx_right_out, 0);
    chk("rst_yout", chany_top_out, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_error", cfg_error, 0);
    chk("rst_tail", ccff_tail, 0);

    // Full frame, every select = straight
    for (int k = 0; k < 2*CW; k++) c[2*k +: 2] = SEL_STRAIGHT;
    shift_frame(mk_frame(c), FRAME_BITS);
    step(1'b0, 1'b0, 1'b1);
    chk("full_done", cfg_done, 1);
    chanx_right_in = 30'h2AAAAAAA; chany_top_in = 30'h15555555;
    #1;
    chk("full_ystraight", chany_top_out, 30'h2AAAAAAA);
    chk("full_xstraight", chanx_right_out, 30'h15555555);

    // Short frame: rejected, active stays cleared
    do_reset();
    chanx_right_in = '1; chany_top_in = '1;
    shift_frame(mk_frame(c), FRAME_BITS - 1);
    step(1'b0, 1'b0, 1'b1);
    chk("short_error", cfg_error, 1);
    chk("short_xout", chanx_right_out, 0);
    chk("short_yout", chany_top_out, 0);

    // Overflow frame, then a good frame clears the error
    shift_frame(mk_frame(c), FRAME_BITS + 1);
    step(1'b0, 1'b0, 1'b1);
    chk("ovf_error", cfg_error, 1);
    chk("ovf_done", cfg_done, 0);
    shift_frame(mk_frame(c), FRAME_BITS);
    step(1'b0, 1'b0, 1'b1);
    chk("good_done", cfg_done, 1);
    chk("good_error", cfg_error, 0);

    // Pad route on chanx_right_out[5]
    c = '0;
    c[11:10] = SEL_PAD;
    shift_frame(mk_frame(c), FRAME_BITS);
    step(1'b0, 1'b0, 1'b1);
    top_pad_in = 4'b0010;
    #1;
    chk("pad_bit5", chanx_right_out[5], 1);
    chk("pad_xout", chanx_right_out, 30'h20);
    top_pad_in = 4'b1101;
    #1;
    chk("pad_bit5_lo", chanx_right_out[5], 0);

    // test_enable forces straight routing
    chanx_right_in = CW'($urandom); chany_top_in = CW'($urandom);
    test_enable = 1'b1;
    #1;
    chk("te_xout", chanx_right_out, chany_top_in);
    chk("te_yout", chany_top_out, chanx_right_in);
    check_all("te");
    test_enable = 1'b0;

    // Tail reproduces head delayed by one full frame of shifts
    sent.delete();
    for (int k = 0; k < 2*FRAME_BITS; k++) begin
      sent.push_back(1'($urandom));
      step(1'b1, sent[k], 1'b0);
      if (k >= FRAME_BITS - 1) chk("tail_delay", ccff_tail, sent[k - (FRAME_BITS - 1)]);
    end
    step(1'b0, 1'b0, 1'b1);
    chk("tail_ovf_error", cfg_error, 1);

`ifdef CFG_PARITY_EN
    // Parity: bad then good
    c = rnd_cfg();
    f = mk_frame(c) ^ FRAME_BITS'(1);
    shift_frame(f, FRAME_BITS);
    step(1'b0, 1'b0, 1'b1);
    chk("par_bad_error", cfg_error, 1);
    chk("par_bad_done", cfg_done, 0);
    shift_frame(mk_frame(c), FRAME_BITS);
    step(1'b0, 1'b0, 1'b1);
    chk("par_good_done", cfg_done, 1);
    chk("par_good_error", cfg_error, 0);
`endif

    // Randomized frames
    rand_data = 1'b1;
    for (int it = 0; it < 30; it++) begin
      c = rnd_cfg();
      f = mk_frame(c);
`ifdef CFG_PARITY_EN
      if ($urandom_range(0, 5) == 0) f = f ^ FRAME_BITS'(1);
`endif
      case ($urandom_range(0, 9))
        7:       d = -1 - int'($urandom_range(0, 2));
        8:       d = 1 + int'($urandom_range(0, 1));
        default: d = 0;
      endcase
      if ($urandom_range(0, 9) == 0) begin
        shift_frame(f, FRAME_BITS / 2);
        do_reset();
      end
      shift_frame(f, FRAME_BITS + d);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) step(1'b0, 1'($urandom), 1'b0);
      step(1'($urandom), 1'($urandom), 1'b1);
      if ($urandom_range(0, 4) == 0) step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
